hazard_issue_ctrl: RTL and testbench

//  Scoreboard-based issue controller for the 20-bit in-order pipeline. It sits at the ID stage.
//  It decides each cycle whether the decoded instruction may enter the ID/EX register. On a hazard
//  it holds IF/ID and injects a bubble (NOP) into ID/EX.
//  It tracks per-register pending writes (RAW/WAW), squashes the wrong-path instruction on a taken

---
 rtl/pipe_pkg.sv | 54 +++++
 rtl/reg_scoreboard.sv | 41 ++++
 rtl/hazard_issue_ctrl.sv | 72 +++++++
 tb/tb_hazard_issue_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the 20-bit in-order pipeline: opcodes, instruction
// field layout, scoreboard sizing and the ID-stage operand decode.
package pipe_pkg;

   localparam int unsigned INSTR_W     = 20;
   localparam int unsigned OP_W        = 4;
   localparam int unsigned REG_W       = 4;
   localparam int unsigned IMM_W       = 4;
   localparam int unsigned OP_LSB      = 16;
   localparam int unsigned RD_LSB      = 12;
   localparam int unsigned RS1_LSB     = 8;
   localparam int unsigned RS2_LSB     = 4;
   localparam int unsigned IMM_LSB     = 0;

   localparam int unsigned NREGS       = 16;
   localparam int unsigned ALU_LAT     = 3;
   localparam int unsigned LOAD_LAT    = 4;
   localparam int unsigned PERF_W_DFLT = 16;
   localparam int unsigned CNT_W       = $clog2(LOAD_LAT + 1);

   localparam logic [OP_W-1:0] OP_NOP = 4'd0;
   localparam logic [OP_W-1:0] OP_LD  = 4'd1;
   localparam logic [OP_W-1:0] OP_ST  = 4'd2;
   localparam logic [OP_W-1:0] OP_ADD = 4'd3;
   localparam logic [OP_W-1:0] OP_SUB = 4'd4;
   localparam logic [OP_W-1:0] OP_AND = 4'd5;
   localparam logic [OP_W-1:0] OP_OR  = 4'd6;
   localparam logic [OP_W-1:0] OP_LI  = 4'd7;
   localparam logic [OP_W-1:0] OP_BEQ = 4'd8;

   typedef struct packed {
      logic uses_rs1;
      logic uses_rs2;
      logic writes_rd;
      logic is_load;
   } dec_t;

   // Operand usage per opcode; unassigned opcodes behave as NOP.
   function automatic dec_t decode(input logic [OP_W-1:0] op);
      dec_t d;
      d = '0;
      case (op)
         OP_LD:  begin d.uses_rs1 = 1'b1; d.writes_rd = 1'b1; d.is_load = 1'b1; end
         OP_ST:  begin d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; end
         OP_ADD, OP_SUB, OP_AND, OP_OR:
                 begin d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; d.writes_rd = 1'b1; end
         OP_LI:  begin d.writes_rd = 1'b1; end
         OP_BEQ: begin d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; end
         default: d = '0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write countdown; a register reads busy until its
// producer's result is visible in ID.
module reg_scoreboard
   import pipe_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             i_set,
   input  logic [REG_W-1:0] i_set_rd,
   input  logic             i_set_load,
   output logic [NREGS-1:0] o_busy
);

   logic [CNT_W-1:0] r_cnt [NREGS];
   logic [CNT_W-1:0] w_set_val;

   always_comb begin
      w_set_val = i_set_load ? CNT_W'(LOAD_LAT) : CNT_W'(ALU_LAT);
   end

   // A new set always wins; the issuing side guarantees the slot was idle.
   always_ff @(posedge clock) begin
      for (int i = 0; i < int'(NREGS); i++) begin
         if (reset) begin
            r_cnt[i] <= '0;
         end else if (i_set && (i_set_rd == REG_W'(i))) begin
            r_cnt[i] <= w_set_val;
         end else if (r_cnt[i] != '0) begin
            r_cnt[i] <= r_cnt[i] - CNT_W'(1);
         end
      end
   end

   always_comb begin
      o_busy = '0;
      for (int i = 0; i < int'(NREGS); i++) begin
         o_busy[i] = (r_cnt[i] != '0);
      end
   end

endmodule

// File: rtl/hazard_issue_ctrl.sv
// ID-stage issue controller: RAW/WAW hazard detection against the register
// scoreboard, wrong-path squash on taken branches and a stall counter.
module hazard_issue_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned PERF_W = PERF_W_DFLT
)(
   input  logic               clock,
   input  logic               reset,
   input  logic               id_valid,
   input  logic [INSTR_W-1:0] id_instr,
   input  logic               br_taken,
   output logic               issue,
   output logic               if_id_hold,
   output logic               id_ex_bubble,
   output logic [PERF_W-1:0]  stall_count
);

   dec_t              w_dec;
   logic [REG_W-1:0]  w_rd;
   logic [REG_W-1:0]  w_rs1;
   logic [REG_W-1:0]  w_rs2;
   logic [NREGS-1:0]  w_busy;
   logic              w_live;
   logic              w_hazard;
   logic              w_issue;
   logic              w_unused_imm;
   logic [PERF_W-1:0] r_stall_count;

   always_comb begin
      w_dec        = decode(id_instr[OP_LSB +: OP_W]);
      w_rd         = id_instr[RD_LSB  +: REG_W];
      w_rs1        = id_instr[RS1_LSB +: REG_W];
      w_rs2        = id_instr[RS2_LSB +: REG_W];
      w_unused_imm = ^id_instr[IMM_LSB +: IMM_W];
   end

   // A squashed or invalid slot can never hazard; reset forces a bubble.
   always_comb begin
      w_live   = ~reset & id_valid & ~br_taken;
      w_hazard = w_live & ((w_dec.uses_rs1  & w_busy[w_rs1]) |
                           (w_dec.uses_rs2  & w_busy[w_rs2]) |
                           (w_dec.writes_rd & w_busy[w_rd]));
      w_issue  = w_live & ~w_hazard;
   end

   always_comb begin
      issue        = w_issue;
      if_id_hold   = w_hazard;
      id_ex_bubble = ~w_issue;
      stall_count  = r_stall_count;
   end

   reg_scoreboard u_scoreboard (
      .clock      (clock),
      .reset      (reset),
      .i_set      (w_issue & w_dec.writes_rd),
      .i_set_rd   (w_rd),
      .i_set_load (w_dec.is_load),
      .o_busy     (w_busy)
   );

   // Saturating hazard-cycle counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_stall_count <= '0;
      end else if (w_hazard && (r_stall_count != '1)) begin
         r_stall_count <= r_stall_count + PERF_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_issue_ctrl.sv
// Directed bench for hazard_issue_ctrl; a second 2-bit-counter instance on the
// same stimulus exercises stall counter saturation.
module tb_hazard_issue_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [19:0] id_instr;
   logic        br_taken;
   logic        issue, if_id_hold, id_ex_bubble;
   logic [15:0] stall_count;
   logic        s_issue, s_hold, s_bubble;
   logic [1:0]  s_stall_count;

   int n_checks   = 0;
   int n_errors   = 0;
   int exp_stalls = 0;

   always #5 clock = ~clock;

   hazard_issue_ctrl dut (
      .clock        (clock),
      .reset        (reset),
      .id_valid     (id_valid),
      .id_instr     (id_instr),
      .br_taken     (br_taken),
      .issue        (issue),
      .if_id_hold   (if_id_hold),
      .id_ex_bubble (id_ex_bubble),
      .stall_count  (stall_count)
   );

   hazard_issue_ctrl #(.PERF_W(2)) dut_sat (
      .clock        (clock),
      .reset        (reset),
      .id_valid     (id_valid),
      .id_instr     (id_instr),
      .br_taken     (br_taken),
      .issue        (s_issue),
      .if_id_hold   (s_hold),
      .id_ex_bubble (s_bubble),
      .stall_count  (s_stall_count)
   );

   function automatic logic [19:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2);
      return {op, rd, rs1, rs2, 4'h0};
   endfunction

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      id_valid = 1'b0;
      br_taken = 1'b0;
      repeat (n) cyc();
   endtask

   // {issue, if_id_hold, id_ex_bubble}: 100 issue, 011 stall, 001 bubble only
   task automatic test_reset();
      reset    = 1'b1;
      id_valid = 1'b1;
      br_taken = 1'b0;
      id_instr = mk(4'd3, 4'd1, 4'd2, 4'd3);
      repeat (2) begin
         cyc();
         n_checks++;
         if ({issue, if_id_hold, id_ex_bubble} !== 3'b001) begin
            n_errors++;
            $display("FAIL reset_ctl: got %b want 001", {issue, if_id_hold, id_ex_bubble});
         end
      end
      n_checks++;
      if (stall_count !== 16'd0) begin
         n_errors++;
         $display("FAIL reset_stall_count: got %0d want 0", stall_count);
      end
      reset = 1'b0;
      #1;
      n_checks++;
      if ({issue, if_id_hold, id_ex_bubble} !== 3'b100) begin
         n_errors++;
         $display("FAIL post_reset_issue: got %b want 100", {issue, if_id_hold, id_ex_bubble});
      end
      cyc();
      idle(5);
   endtask

   task automatic test_raw();
      id_valid = 1'b1;
      id_instr = mk(4'd3, 4'd1, 4'd2, 4'd3);
      #1;
      n_checks++;
      if ({issue, if_id_hold, id_ex_bubble} !== 3'b100) begin
         n_errors++;
         $display("FAIL raw_producer: got %b want 100", {issue, if_id_hold, id_ex_bubble});
      end
      cyc();
      id_instr = mk(4'd4, 4'd4, 4'd1, 4'd5);
      for (int k = 0; k < 3; k++) begin
         #1;
         n_checks++;
         if ({issue, if_id_hold, id_ex_bubble} !== 3'b011) begin
            n_errors++;
            $display("FAIL raw_stall[%0d]: got %b want 011", k, {issue, if_id_hold, id_ex_bubble});
         end
         cyc();
         exp_stalls++;
      end
      #1;
      n_checks++;
      if ({issue, if_id_hold, id_ex_bubble} !== 3'b100) begin
         n_errors++;
         $display("FAIL raw_issue: got %b want 100", {issue, if_id_hold, id_ex_bubble});
      end
      cyc();
      idle(5);
      n_checks++;
      if (stall_count !== 16'(exp_stalls)) begin
         n_errors++;
         $display("FAIL raw_stall_count: got %0d want %0d", stall_count, exp_stalls);
      end
      n_checks++;
      if (s_stall_count !== 2'd3) begin
         n_errors++;
         $display("FAIL sat_reach_max: got %0d want 3", s_stall_count);
      end
   endtask

   task automatic test_load_use();
      id_valid = 1'b1;
      id_instr = mk(4'd1, 4'd2, 4'd6, 4'd0);
      #1;
      n_checks++;
      if ({issue, if_id_hold, id_ex_bubble} !== 3'b100) begin
         n_errors++;
         $display("FAIL ld_issue: got %b want 100", {issue, if_id_hold, id_ex_bubble});
      end
      cyc();
      id_instr = mk(4'd3, 4'd7, 4'd2, 4'd2);
      for (int k = 0; k < 4; k++) begin
         #1;
         n_checks++;
         if ({issue, if_id_hold, id_ex_bubble} !== 3'b011) begin
            n_errors++;
            $display("FAIL load_use_stall[%0d]: got %b want 011", k, {issue, if_id_hold, id_ex_bubble});
         end
         cyc();
         exp_stalls++;
         n_checks++;
         if (s_stall_count !== 2'd3) begin
            n_errors++;
            $display("FAIL sat_hold[%0d]: got %0d want 3", k, s_stall_count);
         end
      end
      #1;
      n_checks++;
      if ({issue, if_id_hold, id_ex_bubble} !== 3'b100) begin
         n_errors++;
         $display("FAIL load_use_issue: got %b want 100", {issue, if_id_hold, id_ex_bubble});
      end
      cyc();
      idle(5);
      n_checks++;
      if (stall_count !== 16'(exp_stalls)) begin
         n_errors++;
         $display("FAIL load_use_count: got %0d want %0d", stall_count, exp_stalls);
      end
   endtask

   task automatic test_waw();
      id_valid = 1'b1;
      id_instr = mk(4'd1, 4'd3, 4'd0, 4'd0);
      cyc();
      id_instr = mk(4'd7, 4'd3, 4'd0, 4'd0);
      for (int k = 0; k < 4; k++) begin
         #1;
         n_checks++;
         if ({issue, if_id_hold, id_ex_bubble} !== 3'b011) begin
            n_errors++;
            $display("FAIL waw_stall[%0d]: got %b want 011", k, {issue, if_id_hold, id_ex_bubble});
         end
         cyc();
         exp_stalls++;
      end
      #1;
      n_checks++;
      if ({issue, if_id_hold, id_ex_bubble} !== 3'b100) begin
         n_errors++;
         $display("FAIL waw_issue: got %b want 100", {issue, if_id_hold, id_ex_bubble});
      end
      cyc();
      // A reader of r3 now waits out the ALU latency, not the load latency.
      id_instr = mk(4'd3, 4'd9, 4'd3, 4'd3);
      for (int k = 0; k < 3; k++) begin
         #1;
         n_checks++;
         if ({issue, if_id_hold, id_ex_bubble} !== 3'b011) begin
            n_errors++;
            $display("FAIL waw_reader_stall[%0d]: got %b want 011", k, {issue, if_id_hold, id_ex_bubble});
         end
         cyc();
         exp_stalls++;
      end
      #1;
      n_checks++;
      if ({issue, if_id_hold, id_ex_bubble} !== 3'b100) begin
         n_errors++;
         $display("FAIL waw_reader_issue: got %b want 100", {issue, if_id_hold, id_ex_bubble});
      end
      cyc();
      idle(5);
   endtask

   task automatic test_squash();
      id_valid = 1'b1;
      id_instr = mk(4'd7, 4'd1, 4'd0, 4'd0);
      cyc();
      br_taken = 1'b1;
      id_instr = mk(4'd3, 4'd8, 4'd1, 4'd1);
      #1;
      n_checks++;
      if ({issue, if_id_hold, id_ex_bubble} !== 3'b001) begin
         n_errors++;
         $display("FAIL squash_ctl: got %b want 001", {issue, if_id_hold, id_ex_bubble});
      end
      cyc();
      br_taken = 1'b0;
      id_instr = mk(4'd3, 4'd10, 4'd8, 4'd8);
      #1;
      n_checks++;
      if ({issue, if_id_hold, id_ex_bubble} !== 3'b100) begin
         n_errors++;
         $display("FAIL squash_no_set: got %b want 100", {issue, if_id_hold, id_ex_bubble});
      end
      cyc();
      idle(5);
      n_checks++;
      if (stall_count !== 16'(exp_stalls)) begin
         n_errors++;
         $display("FAIL squash_no_count: got %0d want %0d", stall_count, exp_stalls);
      end
   endtask

   task automatic test_no_use();
      id_valid = 1'b1;
      id_instr = mk(4'd1, 4'd5, 4'd0, 4'd0);
      cyc();
      id_instr = mk(4'd2, 4'd0, 4'd5, 4'd5);
      for (int k = 0; k < 4; k++) begin
         cyc();
         exp_stalls++;
      end
      #1;
      n_checks++;
      if ({issue, if_id_hold, id_ex_bubble} !== 3'b100) begin
         n_errors++;
         $display("FAIL st_issue: got %b want 100", {issue, if_id_hold, id_ex_bubble});
      end
      cyc();
      id_instr = mk(4'd7, 4'd5, 4'd0, 4'd0);
      #1;
      n_checks++;
      if ({issue, if_id_hold, id_ex_bubble} !== 3'b100) begin
         n_errors++;
         $display("FAIL li_after_st: got %b want 100", {issue, if_id_hold, id_ex_bubble});
      end
      cyc();
      // r6 busy: an invalid slot must not stall, an undefined opcode acts as NOP.
      id_instr = mk(4'd7, 4'd6, 4'd0, 4'd0);
      cyc();
      id_valid = 1'b0;
      id_instr = mk(4'd3, 4'd7, 4'd6, 4'd6);
      #1;
      n_checks++;
      if ({issue, if_id_hold, id_ex_bubble} !== 3'b001) begin
         n_errors++;
         $display("FAIL invalid_ctl: got %b want 001", {issue, if_id_hold, id_ex_bubble});
      end
      cyc();
      id_valid = 1'b1;
      id_instr = mk(4'd12, 4'd6, 4'd6, 4'd6);
      #1;
      n_checks++;
      if ({issue, if_id_hold, id_ex_bubble} !== 3'b100) begin
         n_errors++;
         $display("FAIL undef_op_nop: got %b want 100", {issue, if_id_hold, id_ex_bubble});
      end
      cyc();
      // Register 0 is scoreboarded like the others.
      id_instr = mk(4'd7, 4'd0, 4'd0, 4'd0);
      cyc();
      id_instr = mk(4'd3, 4'd1, 4'd0, 4'd0);
      #1;
      n_checks++;
      if ({issue, if_id_hold, id_ex_bubble} !== 3'b011) begin
         n_errors++;
         $display("FAIL r0_tracked: got %b want 011", {issue, if_id_hold, id_ex_bubble});
      end
      repeat (3) begin
         cyc();
         exp_stalls++;
      end
      idle(5);
      n_checks++;
      if (stall_count !== 16'(exp_stalls)) begin
         n_errors++;
         $display("FAIL no_use_count: got %0d want %0d", stall_count, exp_stalls);
      end
   endtask

   task automatic test_reset_mid_stall();
      id_valid = 1'b1;
      id_instr = mk(4'd1, 4'd2, 4'd6, 4'd0);
      cyc();
      id_instr = mk(4'd3, 4'd7, 4'd2, 4'd2);
      cyc();
      reset = 1'b1;
      #1;
      n_checks++;
      if ({issue, if_id_hold, id_ex_bubble} !== 3'b001) begin
         n_errors++;
         $display("FAIL mid_reset_ctl: got %b want 001", {issue, if_id_hold, id_ex_bubble});
      end
      cyc();
      reset = 1'b0;
      exp_stalls = 0;
      #1;
      n_checks++;
      if ({issue, if_id_hold, id_ex_bubble} !== 3'b100) begin
         n_errors++;
         $display("FAIL mid_reset_issue: got %b want 100", {issue, if_id_hold, id_ex_bubble});
      end
      n_checks++;
      if (stall_count !== 16'(exp_stalls) || s_stall_count !== 2'd0) begin
         n_errors++;
         $display("FAIL mid_reset_count: got %0d/%0d want 0/0", stall_count, s_stall_count);
      end
      cyc();
      idle(2);
   endtask

   initial begin
      reset    = 1'b1;
      id_valid = 1'b0;
      br_taken = 1'b0;
      id_instr = '0;
      test_reset();
      test_raw();
      test_load_use();
      test_waw();
      test_squash();
      test_no_use();
      test_reset_mid_stall();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
